// File: rtl/wb_tone_seq.sv
// wb_tone_seq: Wishbone-slave note sequencer feeding a tone generator.
// Software queues {code, duration} notes into a FIFO. The sequencer plays
// them back in order, inserts GAP_TICKS silent ticks after each note, and
// flags "done" (optionally as an interrupt) when the queue drains.
//
// Ports:
//   clk, reset           - system clock, synchronous active-high reset
//   wb_adr_i[5:2]        - register select (0 STATUS, 1 NOTE, 2 CTRL, 3 PRESCALE)
//   wb_dat_i / wb_dat_o  - write data / registered read data
//   wb_sel_i             - ignored, all accesses are full-word
//   wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o - Wishbone handshake (2-cycle access)
//   tone_code            - code to the tone generator, 0 = silent
//   busy                 - sequencer FSM is not idle
//   irq                  - done & irq_en
module wb_tone_seq #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned GAP_TICKS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    input  logic        wb_we_i,
    output logic [7:0]  tone_code,
    output logic        busy,
    output logic        irq
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t        state;
    logic          ack;
    logic          run;
    logic          irq_en;
    logic [15:0]   prescale;
    logic [15:0]   presc_cnt;
    logic [15:0]   cnt;
    logic          done;
    logic          overflow;

    logic [7:0]    code_mem [DEPTH];
    logic [15:0]   dur_mem  [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [3:0]    reg_sel;
    logic          access;
    logic          wr_en;
    logic          push_req;
    logic          push_ok;
    logic          flush_req;
    logic          clr_done;
    logic          clr_ovf;
    logic          full;
    logic          empty;
    logic          tick;
    logic          last_tick;
    logic          pop;
    logic [15:0]   head_dur;
    logic [15:0]   head_cnt;
    logic [4:0]    count_ext;
    logic [31:0]   rd_val;
    logic          unused_bits;

    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i[31:24], count_ext[4]};

    // Bus decode: an access acts in the first strobed cycle without ack.
    assign reg_sel   = wb_adr_i[5:2];
    assign access    = wb_stb_i & wb_cyc_i & ~ack;
    assign wr_en     = access & wb_we_i;
    assign push_req  = wr_en & (reg_sel == 4'd1);
    assign flush_req = wr_en & (reg_sel == 4'd2) & wb_dat_i[1];
    assign clr_done  = wr_en & (reg_sel == 4'd0) & wb_dat_i[3];
    assign clr_ovf   = wr_en & (reg_sel == 4'd0) & wb_dat_i[4];
    assign wb_ack_o  = wb_stb_i & wb_cyc_i & ack;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign busy      = (state != IDLE);
    assign irq       = done & irq_en;

    assign tick      = (presc_cnt == '0);
    assign last_tick = tick & (cnt == 16'd1);
    assign head_dur  = dur_mem[rd_ptr];
    assign head_cnt  = (head_dur == '0) ? 16'd1 : head_dur;
    // A push into a full FIFO is still accepted when the head leaves this cycle.
    assign push_ok   = push_req & (~full | pop);
    assign count_ext = 5'(count);

    // Pop only where the FSM is about to start a note; flush always wins.
    always_comb begin
        pop = 1'b0;
        if (!flush_req && run && !empty) begin
            unique case (state)
                IDLE:    pop = 1'b1;
                PLAY:    pop = last_tick && (GAP_TICKS == 0);
                GAP:     pop = last_tick;
                default: pop = 1'b0;
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        case (reg_sel)
            4'd0:    rd_val = {20'b0, count_ext[3:0], 3'b0, overflow, done, empty, full, busy};
            4'd2:    rd_val = {29'b0, irq_en, 1'b0, run};
            4'd3:    rd_val = {16'b0, prescale};
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack      <= 1'b0;
            wb_dat_o <= '0;
            run      <= 1'b0;
            irq_en   <= 1'b0;
            prescale <= '0;
        end else begin
            ack      <= access;
            wb_dat_o <= (access && !wb_we_i) ? rd_val : '0;
            if (wr_en && reg_sel == 4'd2) begin
                run    <= wb_dat_i[0];
                irq_en <= wb_dat_i[2];
            end
            if (wr_en && reg_sel == 4'd3) begin
                prescale <= wb_dat_i[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            code_mem[wr_ptr] <= wb_dat_i[7:0];
            dur_mem[wr_ptr]  <= wb_dat_i[23:8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (clr_ovf) begin
                overflow <= 1'b0;
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
            if (flush_req) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push_ok && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push_ok) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tone_code <= '0;
            cnt       <= '0;
            presc_cnt <= '0;
            done      <= 1'b0;
        end else begin
            presc_cnt <= tick ? prescale : presc_cnt - 1'b1;
            if (clr_done) begin
                done <= 1'b0;
            end
            if (flush_req || (state != IDLE && !run)) begin
                state     <= IDLE;
                tone_code <= '0;
            end else if (pop) begin
                state     <= PLAY;
                tone_code <= code_mem[rd_ptr];
                cnt       <= head_cnt;
                presc_cnt <= prescale;
            end else if (state != IDLE && tick) begin
                if (cnt != 16'd1) begin
                    cnt <= cnt - 1'b1;
                end else if (state == PLAY && GAP_TICKS != 0) begin
                    state     <= GAP;
                    tone_code <= '0;
                    cnt       <= 16'(GAP_TICKS);
                    presc_cnt <= prescale;
                end else begin
                    // No pop with run set means the queue has drained.
                    state     <= IDLE;
                    tone_code <= '0;
                    if (empty) begin
                        done <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_tone_seq.sv
// tb_wb_tone_seq: directed scoreboard bench for wb_tone_seq (DEPTH=8, GAP_TICKS=1).
module tb_wb_tone_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    logic        wb_we_i;
    logic [7:0]  tone_code;
    logic        busy;
    logic        irq;

    always #5 clk = ~clk;

    wb_tone_seq #(.DEPTH(8), .GAP_TICKS(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_i  (wb_sel_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_ack_o  (wb_ack_o),
        .wb_we_i   (wb_we_i),
        .tone_code (tone_code),
        .busy      (busy),
        .irq       (irq)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_obs(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            e.tag = "scoreboard_underflow";
            e.val = 'x;
        end else begin
            e = sb.pop_front();
        end
        n_assert++;
        assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", e.tag, obs, e.val);
        end
    endtask

    task automatic wb_access(input logic we, input logic [3:0] idx,
                             input logic [31:0] data, output logic [31:0] rdata);
        logic got_ack;
        got_ack  = 1'b0;
        wb_adr_i = {26'b0, idx, 2'b00};
        wb_dat_i = data;
        wb_we_i  = we;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (wb_ack_o) begin
                got_ack = 1'b1;
                break;
            end
        end
        n_assert++;
        assert (got_ack === 1'b1) else begin
            n_fail++;
            $error("FAIL bus_ack_timeout observed=%0b expected=1", got_ack);
        end
        rdata    = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [3:0] idx, input logic [31:0] data);
        logic [31:0] unused_rd;
        wb_access(1'b1, idx, data, unused_rd);
    endtask

    task automatic rd_check(input string tag, input logic [3:0] idx, input logic [31:0] exp);
        logic [31:0] r;
        expect_val(tag, exp);
        wb_access(1'b0, idx, 32'h0, r);
        check_obs(r);
    endtask

    task automatic sig_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        expect_val(tag, exp);
        check_obs(obs);
    endtask

    // Samples tone_code once per cycle against already-queued expectations.
    task automatic tone_run(input int n);
        for (int i = 0; i < n; i++) begin
            check_obs({24'b0, tone_code});
            cyc();
        end
    endtask

    task automatic expect_tone(input string name, input int idx, input logic [7:0] code, input int n);
        for (int i = 0; i < n; i++) begin
            expect_val($sformatf("%s_tone%0d", name, idx + i), {24'b0, code});
        end
    endtask

    initial begin
        reset    = 1'b1;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_sel_i = 4'hF;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;

        sig_check("rst_tone", {24'b0, tone_code}, 32'h0);
        sig_check("rst_busy", {31'b0, busy}, 32'h0);
        sig_check("rst_irq", {31'b0, irq}, 32'h0);
        rd_check("rst_status", 4'd0, 32'h0000_0004);

        // Reset in the middle of a note with one more note queued.
        wr(4'd3, 32'd3);
        wr(4'd2, 32'h1);
        wr(4'd1, {8'h0, 16'd10, 8'h21});
        wr(4'd1, {8'h0, 16'd5, 8'h22});
        repeat (10) cyc();
        sig_check("midnote_tone", {24'b0, tone_code}, 32'h21);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        sig_check("rst2_tone", {24'b0, tone_code}, 32'h0);
        sig_check("rst2_busy", {31'b0, busy}, 32'h0);
        sig_check("rst2_irq", {31'b0, irq}, 32'h0);
        sig_check("rst2_ack", {31'b0, wb_ack_o}, 32'h0);
        sig_check("rst2_dat", wb_dat_o, 32'h0);
        rd_check("rst2_status", 4'd0, 32'h0000_0004);
        rd_check("rst2_ctrl", 4'd2, 32'h0);
        rd_check("rst2_prescale", 4'd3, 32'h0);

        // Single note, PRESCALE=3: 20 cycles of code then 4 silent cycles.
        wr(4'd3, 32'd3);
        wr(4'd2, 32'h1);
        expect_tone("single", 0, 8'h00, 1);
        expect_tone("single", 1, 8'h12, 20);
        expect_tone("single", 21, 8'h00, 4);
        wr(4'd1, {8'h0, 16'd5, 8'h12});
        tone_run(25);
        sig_check("single_busy", {31'b0, busy}, 32'h0);
        sig_check("single_irq_masked", {31'b0, irq}, 32'h0);
        rd_check("single_status", 4'd0, 32'h0000_000C);
        wr(4'd0, 32'h8);
        rd_check("single_status_clr", 4'd0, 32'h0000_0004);

        // Three notes including a rest and a zero duration, PRESCALE=0.
        wr(4'd2, 32'h0);
        wr(4'd3, 32'd0);
        wr(4'd1, {8'h0, 16'd2, 8'h01});
        wr(4'd1, {8'h0, 16'd3, 8'h00});
        wr(4'd1, {8'h0, 16'd0, 8'h05});
        expect_tone("seq3", 0, 8'h00, 1);
        expect_tone("seq3", 1, 8'h01, 2);
        expect_tone("seq3", 3, 8'h00, 5);
        expect_tone("seq3", 8, 8'h05, 1);
        expect_tone("seq3", 9, 8'h00, 1);
        wr(4'd2, 32'h5);
        tone_run(10);
        sig_check("seq3_busy", {31'b0, busy}, 32'h0);
        sig_check("seq3_irq", {31'b0, irq}, 32'h1);
        wr(4'd0, 32'h8);
        sig_check("seq3_irq_clr", {31'b0, irq}, 32'h0);

        // Overflow: nine pushes with run=0, the ninth is dropped.
        wr(4'd2, 32'h0);
        for (int i = 0; i < 9; i++) begin
            wr(4'd1, {8'h0, 16'd1, 8'(8'h31 + i)});
        end
        rd_check("ovf_status", 4'd0, 32'h0000_0812);
        expect_tone("ovf", 0, 8'h00, 1);
        for (int i = 0; i < 8; i++) begin
            expect_tone("ovf", 1 + 2 * i, 8'(8'h31 + i), 1);
            expect_tone("ovf", 2 + 2 * i, 8'h00, 1);
        end
        wr(4'd2, 32'h1);
        tone_run(17);
        sig_check("ovf_busy", {31'b0, busy}, 32'h0);
        rd_check("ovf_status_end", 4'd0, 32'h0000_001C);
        wr(4'd0, 32'h18);
        rd_check("ovf_status_clr", 4'd0, 32'h0000_0004);

        // Abort by clearing run mid-note; the queued note survives.
        wr(4'd2, 32'h0);
        wr(4'd1, {8'h0, 16'd20, 8'h41});
        wr(4'd1, {8'h0, 16'd1, 8'h42});
        wr(4'd2, 32'h1);
        repeat (5) cyc();
        sig_check("abort_playing", {24'b0, tone_code}, 32'h41);
        wr(4'd2, 32'h0);
        cyc();
        sig_check("abort_tone", {24'b0, tone_code}, 32'h0);
        sig_check("abort_busy", {31'b0, busy}, 32'h0);
        rd_check("abort_status", 4'd0, 32'h0000_0100);
        expect_tone("resume", 0, 8'h00, 1);
        expect_tone("resume", 1, 8'h42, 1);
        expect_tone("resume", 2, 8'h00, 1);
        wr(4'd2, 32'h1);
        tone_run(3);
        rd_check("resume_status", 4'd0, 32'h0000_000C);
        wr(4'd0, 32'h8);

        // Full FIFO while playing: push coinciding with a pop, then flush.
        wr(4'd2, 32'h0);
        wr(4'd1, {8'h0, 16'd2, 8'h60});
        for (int i = 1; i < 8; i++) begin
            wr(4'd1, {8'h0, 16'd10, 8'(8'h60 + i)});
        end
        wr(4'd2, 32'h1);
        wr(4'd1, {8'h0, 16'd10, 8'h68});
        wr(4'd1, {8'h0, 16'd10, 8'h69});
        rd_check("fullpop_status", 4'd0, 32'h0000_0803);
        sig_check("fullpop_tone", {24'b0, tone_code}, 32'h61);
        wr(4'd2, 32'h3);
        sig_check("flush_tone", {24'b0, tone_code}, 32'h0);
        sig_check("flush_busy", {31'b0, busy}, 32'h0);
        rd_check("flush_status", 4'd0, 32'h0000_0004);
        rd_check("flush_ctrl", 4'd2, 32'h0000_0001);
        wr(4'd2, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
